// File: rtl/fsk_pkg.sv
// Shared constants and types for the FSK frame receiver and its Hamming(12,8) corrector.
package fsk_pkg;

  localparam int unsigned SAMPLES_PER_BIT_DEF = 16;
  localparam int unsigned EDGE_THRESH_DEF     = 6;
  localparam int unsigned BITS_PER_FRAME      = 12;

  // Codeword positions (1-based) carrying dataout[0] .. dataout[7]; the rest are parity.
  localparam int unsigned DATA_POS [8] = '{3, 5, 6, 7, 9, 10, 11, 12};

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StDecode
  } state_e;

endpackage

// File: rtl/hamming12_8_correct.sv
// Combinational Hamming(12,8) syndrome check: fixes one flipped position, flags syndromes
// that point past the end of the codeword, and extracts the data byte.
module hamming12_8_correct
  import fsk_pkg::*;
(
  input  logic [11:0] codeword,
  output logic [7:0]  data,
  output logic        corrected,
  output logic        uncorrectable
);

  logic [3:0]  syndrome;
  logic [11:0] fixed;

  always_comb begin
    syndrome = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (codeword[i]) begin
        syndrome = syndrome ^ 4'(i + 1);
      end
    end

    fixed         = codeword;
    corrected     = 1'b0;
    uncorrectable = 1'b0;
    if (syndrome > 4'd12) begin
      uncorrectable = 1'b1;
    end else if (syndrome != 4'd0) begin
      fixed[syndrome - 4'd1] = ~codeword[syndrome - 4'd1];
      corrected              = 1'b1;
    end

    for (int k = 0; k < 8; k++) begin
      data[k] = fixed[DATA_POS[k] - 1];
    end
  end

endmodule

// File: rtl/fsk_frame_rx.sv
// FSK frame receiver: counts line edges per oversampled bit window, shifts in a 12-bit
// Hamming codeword MSB first, then corrects and presents the byte with a one-cycle strobe.
module fsk_frame_rx
  import fsk_pkg::*;
#(
  parameter int unsigned SAMPLES_PER_BIT = SAMPLES_PER_BIT_DEF,
  parameter int unsigned EDGE_THRESH     = EDGE_THRESH_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fskdata,
  input  logic       frame_sync,
  output logic [7:0] dataout,
  output logic       valid,
  output logic       corrected,
  output logic       uncorrectable,
  output logic       busy
);

  localparam int unsigned SW = (SAMPLES_PER_BIT > 1) ? $clog2(SAMPLES_PER_BIT) : 1;
  localparam logic [SW-1:0] LAST_SAMPLE = SW'(SAMPLES_PER_BIT - 1);
  localparam logic [3:0] LAST_BIT = 4'(BITS_PER_FRAME - 1);

  state_e state_q, state_d;
  logic prev_sample_q;
  logic [SW-1:0] samp_q, samp_d, cur_samp;
  logic [3:0] bit_q, bit_d, cur_bit;
  logic [3:0] edges_q, edges_d, cur_edges, edges_next;
  logic [BITS_PER_FRAME-1:0] sr_q, sr_d, cur_sr;
  logic [7:0] data_q, data_d, dec_data;
  logic valid_q, valid_d, corr_q, corr_d, unc_q, unc_d;
  logic dec_corr, dec_unc;
  logic recv, edge_now, window_end, bit_val;

  hamming12_8_correct u_correct (
    .codeword      (sr_q),
    .data          (dec_data),
    .corrected     (dec_corr),
    .uncorrectable (dec_unc)
  );

  always_comb begin
    // frame_sync in any state starts a fresh frame at this very sample.
    recv       = frame_sync || (state_q == StRecv);
    cur_samp   = frame_sync ? '0 : samp_q;
    cur_bit    = frame_sync ? 4'd0 : bit_q;
    cur_sr     = frame_sync ? '0 : sr_q;
    cur_edges  = (cur_samp == '0) ? 4'd0 : edges_q;
    edge_now   = fskdata ^ prev_sample_q;
    edges_next = (cur_edges == 4'hf) ? cur_edges : cur_edges + {3'b000, edge_now};
    window_end = (cur_samp == LAST_SAMPLE);
    bit_val    = ({28'd0, edges_next} >= EDGE_THRESH);

    state_d = state_q;
    samp_d  = samp_q;
    bit_d   = bit_q;
    edges_d = edges_q;
    sr_d    = sr_q;
    valid_d = 1'b0;
    data_d  = data_q;
    corr_d  = corr_q;
    unc_d   = unc_q;

    if (state_q == StDecode) begin
      state_d = StIdle;
      valid_d = 1'b1;
      data_d  = dec_data;
      corr_d  = dec_corr;
      unc_d   = dec_unc;
    end

    if (recv) begin
      state_d = StRecv;
      edges_d = edges_next;
      bit_d   = cur_bit;
      sr_d    = cur_sr;
      samp_d  = cur_samp + SW'(1);
      if (window_end) begin
        samp_d = '0;
        sr_d   = {cur_sr[BITS_PER_FRAME-2:0], bit_val};
        if (cur_bit == LAST_BIT) begin
          state_d = StDecode;
        end else begin
          bit_d = cur_bit + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      prev_sample_q <= 1'b0;
      samp_q        <= '0;
      bit_q         <= 4'd0;
      edges_q       <= 4'd0;
      sr_q          <= '0;
      data_q        <= 8'h00;
      valid_q       <= 1'b0;
      corr_q        <= 1'b0;
      unc_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_sample_q <= fskdata;
      samp_q        <= samp_d;
      bit_q         <= bit_d;
      edges_q       <= edges_d;
      sr_q          <= sr_d;
      data_q        <= data_d;
      valid_q       <= valid_d;
      corr_q        <= corr_d;
      unc_q         <= unc_d;
    end
  end

  assign dataout       = data_q;
  assign valid         = valid_q;
  assign corrected     = corr_q;
  assign uncorrectable = unc_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_fsk_frame_rx.sv
// Scoreboard bench for fsk_frame_rx: tone-encoded random codewords in, a queue of expected
// results checked by an independent monitor on every valid strobe.
module tb_fsk_frame_rx;

  localparam int SPB   = 16;
  localparam int NBITS = 12;
  localparam int LAT   = NBITS * SPB + 1;
  localparam int DPOS [8] = '{3, 5, 6, 7, 9, 10, 11, 12};

  typedef struct {
    logic [7:0]  d;
    logic        c;
    logic        u;
    int unsigned cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic fskdata = 1'b0;
  logic frame_sync = 1'b0;
  logic [7:0] dataout;
  logic valid, corrected, uncorrectable, busy;

  int unsigned cyc = 0;
  int errors = 0;
  int checks = 0;
  logic rst_q = 1'b1;
  logic [7:0] hold_d = 8'h00;
  logic hold_c = 1'b0;
  logic hold_u = 1'b0;
  exp_t exp_q[$];

  fsk_frame_rx #(
    .SAMPLES_PER_BIT (SPB),
    .EDGE_THRESH     (6)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .fskdata       (fskdata),
    .frame_sync    (frame_sync),
    .dataout       (dataout),
    .valid         (valid),
    .corrected     (corrected),
    .uncorrectable (uncorrectable),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [3:0] syndrome(input logic [11:0] cw);
    logic [3:0] s = 4'd0;
    for (int i = 1; i <= 12; i++) if (cw[i-1]) s = s ^ 4'(i);
    return s;
  endfunction

  // Parity bits take the syndrome of the data-only word so the full word checks to zero.
  function automatic logic [11:0] encode(input logic [7:0] d);
    logic [11:0] cw = 12'd0;
    logic [3:0] s;
    for (int k = 0; k < 8; k++) cw[DPOS[k]-1] = d[k];
    s = syndrome(cw);
    cw[0] = s[0];
    cw[1] = s[1];
    cw[3] = s[2];
    cw[7] = s[3];
    return cw;
  endfunction

  function automatic exp_t model(input logic [11:0] rx, input int unsigned at);
    exp_t e;
    logic [3:0] s = syndrome(rx);
    logic [11:0] f = rx;
    e.c = 1'b0;
    e.u = 1'b0;
    if (s > 4'd12) e.u = 1'b1;
    else if (s != 4'd0) begin
      f[s-1] = ~f[s-1];
      e.c = 1'b1;
    end
    for (int k = 0; k < 8; k++) e.d[k] = f[DPOS[k]-1];
    e.cyc = at;
    return e;
  endfunction

  function automatic logic tone(input logic b, input int s, input int ph);
    int half = b ? 2 : 4;
    return (((s + ph) / half) % 2) == 1;
  endfunction

  task automatic send_frame(input logic [11:0] cw, input int n, input bit rst_last,
                            input bit push);
    int ph = 0;
    int unsigned t0 = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == 0) t0 = cyc;
      frame_sync = (k == 0);
      reset = rst_last && (k == n - 1);
      if (k % SPB == 0) ph = $urandom_range(0, 7);
      fskdata = tone(cw[NBITS-1-k/SPB], k % SPB, ph);
      if (k == 40) chk("busy_in_recv", 32'(busy), 32'd1);
    end
    if (push) exp_q.push_back(model(cw, t0 + LAT));
  endtask

  task automatic idle(input int n, input bit rst_first);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      frame_sync = 1'b0;
      reset = rst_first && (k == 0);
      fskdata = 1'($urandom_range(0, 1));
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_q) begin
      chk("reset_outputs", 32'({valid, busy, corrected, uncorrectable, dataout}), 32'd0);
      hold_d = 8'h00;
      hold_c = 1'b0;
      hold_u = 1'b0;
    end else if (valid) begin
      chk("valid_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("valid_cycle", cyc, e.cyc);
        chk("dataout", 32'(dataout), 32'(e.d));
        chk("corrected", 32'(corrected), 32'(e.c));
        chk("uncorrectable", 32'(uncorrectable), 32'(e.u));
        hold_d = e.d;
        hold_c = e.c;
        hold_u = e.u;
      end
    end else begin
      chk("hold_outputs", 32'({dataout, corrected, uncorrectable}),
          32'({hold_d, hold_c, hold_u}));
    end
  end

  initial begin
    logic [11:0] cw;
    logic [7:0] d;
    int nerr;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle(5, 0);

    send_frame(encode(8'hA5), NBITS * SPB, 0, 1);
    idle(10, 0);
    cw = encode(8'h3C);
    cw[5] = ~cw[5];
    send_frame(cw, NBITS * SPB, 0, 1);
    idle(10, 0);
    cw = encode(8'h5A);
    cw[0] = ~cw[0];
    cw[3] = ~cw[3];
    cw[7] = ~cw[7];
    send_frame(cw, NBITS * SPB, 0, 1);
    idle(10, 0);

    // Resync partway into bit 5 of an abandoned frame.
    send_frame(encode(8'h42), 5 * SPB + 3, 0, 0);
    send_frame(encode(8'h81), NBITS * SPB, 0, 1);
    idle(10, 0);

    // Reset during bit 10, then a normal frame.
    send_frame(encode(8'h99), 10 * SPB + 5, 1, 0);
    idle(5, 0);
    send_frame(encode(8'h6E), NBITS * SPB, 0, 1);
    idle(10, 0);

    // Reset on the last sample, in DECODE, and together with frame_sync.
    send_frame(encode(8'h12), NBITS * SPB, 1, 0);
    idle(5, 0);
    send_frame(encode(8'h34), NBITS * SPB, 0, 0);
    idle(5, 1);
    @(negedge clk);
    reset = 1'b1;
    frame_sync = 1'b1;
    idle(LAT + 20, 0);

    // Back-to-back: second frame_sync lands in the DECODE cycle.
    send_frame(encode(8'h00), NBITS * SPB, 0, 1);
    send_frame(encode(8'hFF), NBITS * SPB, 0, 1);
    idle(10, 0);

    repeat (24) begin
      d = 8'($urandom);
      cw = encode(d);
      nerr = $urandom_range(0, 2);
      for (int j = 0; j < nerr; j++) begin
        int p = $urandom_range(0, 11);
        cw[p] = ~cw[p];
      end
      send_frame(cw, NBITS * SPB, 0, 1);
      idle($urandom_range(0, 12), 0);
    end

    idle(LAT + 20, 0);
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fsk_frame_rx.md
FSK_FRAME_RX -- requirements
Module: fsk_frame_rx

Interface
REQ-001 SHALL have parameter SAMPLES_PER_BIT, default 16: oversampling clock cycles per FSK bit window.
REQ-002 SHALL have parameter EDGE_THRESH, default 6: edges per window at or above which the bit decodes as '1'.
REQ-003 SHALL have port clk, input, 1: sample clock, same rate as the 32x system clock; one clock domain only.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port fskdata, input, 1: FSK line; '1' tone has a 4-clk period and '0' tone has an 8-clk period.
REQ-006 SHALL have port frame_sync, input, 1: one-cycle pulse marking the first sample of bit 0 of a frame.
REQ-007 SHALL have port dataout, output, 8: corrected log-PCM byte.
REQ-008 SHALL have port valid, output, 1: one-cycle strobe qualifying dataout and the flags.
REQ-009 SHALL have port corrected, output, 1: a single-bit error was corrected.
REQ-010 SHALL have port uncorrectable, output, 1: syndrome > 12, so the data is passed uncorrected.
REQ-011 SHALL have port busy, output, 1: high in RECV and DECODE.

Function
REQ-012 SHALL implement FSM states IDLE, RECV and DECODE.
- IDLE -> RECV on frame_sync.
- RECV -> DECODE after sample SAMPLES_PER_BIT-1 of bit 11.
- DECODE -> IDLE after one cycle.
REQ-013 SHALL register fskdata every cycle into prev_sample.
- An edge is counted in the current window when fskdata != prev_sample.
- This includes the first sample of a window.
REQ-014 SHALL run a per-window 4-bit saturating edge counter, cleared at each window start.
- At window end, bit = (count >= EDGE_THRESH).
REQ-015 SHALL receive 12 bits MSB first, i.e. codeword position 12 first and position 1 last.
- Codeword bit index i-1 holds Hamming position i.
REQ-016 SHALL use the Hamming(12,8) layout: parity at positions 1, 2, 4, 8; data at 3, 5, 6, 7, 9, 10, 11, 12.
- dataout[0] maps to position 3 and dataout[7] maps to position 12.
REQ-017 SHALL compute the syndrome in DECODE.
- Syndrome 0: no error.
- Syndrome 1..12: flip that position and set corrected.
- Syndrome 13..15: no flip, set uncorrectable.
REQ-018 SHALL meet this latency: for frame_sync in cycle T, valid is high in cycle T + 12*SAMPLES_PER_BIT + 1 only (T+193 at default).
REQ-019 SHALL hold dataout and the flags until the next valid; they change only together with valid.
REQ-020 SHALL restart on frame_sync during RECV.
- Counters clear and the new frame begins at that sample.
- The aborted frame produces no valid.
REQ-021 SHALL accept frame_sync during DECODE as a new frame start; the previous frame's valid is still produced.
REQ-022 SHALL ignore fskdata in IDLE except for updating prev_sample.

Reset
REQ-023 SHALL, on reset, force state IDLE and clear all counters and the shift register.
- Outputs: dataout=8'h00, valid=0, corrected=0, uncorrectable=0, busy=0, prev_sample=0.
REQ-024 SHALL, on reset asserted mid-frame, abandon the frame with no valid, including when reset coincides with the last sample or DECODE.
REQ-025 SHALL give reset priority over a simultaneous frame_sync.

Structure
REQ-026 SHALL place the following in shared package fsk_pkg:
- SAMPLES_PER_BIT default.
- BITS_PER_FRAME=12.
- EDGE_THRESH default.
- State enum.
- Hamming position constants.
REQ-027 SHALL put syndrome computation and correction in combinational sub-module hamming12_8_correct (12-bit in; 8-bit data, corrected and uncorrectable out).
REQ-028 SHALL keep the FSM, edge counter, window and bit counters, and shift register in fsk_frame_rx.

Verification
REQ-029 SHALL cover a clean frame: codeword for data 8'hA5 sent as tones after frame_sync at T -> valid at T+193, dataout=8'hA5, corrected=0, uncorrectable=0.
REQ-030 SHALL cover a single-bit error: codeword for 8'h3C with position 6 inverted -> dataout=8'h3C, corrected=1.
REQ-031 SHALL cover an uncorrectable error: codeword with positions 1, 4 and 8 flipped (syndrome 13) -> uncorrectable=1, corrected=0, raw data bits output.
REQ-032 SHALL cover a resync: second frame_sync at bit 5 of frame A, then frame B = 8'h81 -> exactly one valid, at T_B+193, dataout=8'h81.
REQ-033 SHALL cover reset mid-frame: reset during bit 10 -> no valid, all outputs 0, busy=0 next cycle, next frame decodes normally.
REQ-034 SHALL cover back-to-back frames: frame_sync in the DECODE cycle, data 8'h00 then 8'hFF -> two valids 192 cycles apart with correct data.
